// File: rtl/tpu_bridge_pkg.sv
// rtl/tpu_bridge_pkg.sv - shared constants, FSM encoding and helpers for tpu_host_bridge
// Contents: region base addresses, region index width, err_flags bit positions,
//           bridge FSM state enum, signed int8 saturation helper.
package tpu_bridge_pkg;

  localparam logic [7:0] WEIGHT_BASE = 8'h00;
  localparam logic [7:0] ACT_BASE    = 8'h40;
  localparam logic [7:0] RESULT_BASE = 8'h80;

  // Offset within a 64-byte host region.
  localparam int IDX_W = 6;

  localparam int ERR_WR_BUSY   = 0;
  localparam int ERR_RES_STRAY = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_W  = 3'd1,
    ST_SEND_A  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Clamp a signed 16-bit accumulator into the signed 8-bit range.
  function automatic logic [7:0] sat_s8(input logic [15:0] v);
    logic signed [15:0] s;
    s = signed'(v);
    if (s > 16'sd127) begin
      return 8'h7F;
    end else if (s < -16'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/tpu_bridge_buf.sv
// rtl/tpu_bridge_buf.sv - DEPTH x DATA_W register buffer with one write and two async read ports
// Ports: clk, rst_n (async active-low)
//        we, widx, wdata         : host write port, lands on the clock edge
//        host_idx, host_rdata    : combinational host read, 0 for idx >= DEPTH
//        strm_idx, strm_rdata    : combinational streamer read, 0 for idx >= DEPTH
module tpu_bridge_buf
  import tpu_bridge_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int CW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  host_idx,
  output logic [DATA_W-1:0] host_rdata,
  input  logic [CW-1:0]     strm_idx,
  output logic [DATA_W-1:0] strm_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we && (widx == IDX_W'(i))) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Compare-and-select reads so out-of-range indices fall through to zero.
  always_comb begin
    host_rdata = '0;
    strm_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (host_idx == IDX_W'(i)) begin
        host_rdata = mem[i];
      end
      if (strm_idx == CW'(i)) begin
        strm_rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/tpu_host_bridge.sv
// rtl/tpu_host_bridge.sv - host-side buffers and weight/activation streamer for the systolic engine
// Ports: clk, rst_n (async active-low)
//        host_addr/host_wdata/host_we/host_start : byte writes and run start from the UART side
//        host_rdata (combinational), host_busy, host_done, err_flags (sticky)
//        s_data/s_sel/s_last/s_valid/s_ready     : weight then activation stream to the engine
//        r_data/r_valid                          : result strobe from the engine, no backpressure
// Build option: define TPU_BRIDGE_RESULT_SAT_EN for int8-saturated result readback at 0x80+i;
//               otherwise results read back as low/high bytes at 0x80+2i / 0x81+2i.
module tpu_host_bridge
  import tpu_bridge_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  input  logic              host_start,
  output logic [7:0]        host_rdata,
  output logic              host_busy,
  output logic              host_done,
  output logic [1:0]        err_flags,
  output logic [DATA_W-1:0] s_data,
  output logic              s_sel,
  output logic              s_last,
  output logic              s_valid,
  input  logic              s_ready,
  input  logic [ACC_W-1:0]  r_data,
  input  logic              r_valid
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     rcnt;
  logic [1:0]        err_q;
  logic [ACC_W-1:0]  result [DEPTH];

  logic              host_idle;
  logic              start_ok;
  logic              wr_ok;
  logic              in_w_rgn;
  logic              in_a_rgn;
  logic              in_r_rgn;
  logic              fire;
  logic              beat_last;
  logic              res_take;
  logic [DATA_W-1:0] w_host, a_host, w_strm, a_strm;

  assign host_idle = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok  = host_start && host_idle;
  assign wr_ok     = host_we && host_idle;
  assign in_w_rgn  = host_addr[7:6] == WEIGHT_BASE[7:6];
  assign in_a_rgn  = host_addr[7:6] == ACT_BASE[7:6];
  assign in_r_rgn  = host_addr[7] == RESULT_BASE[7];
  assign fire      = s_valid && s_ready;
  assign beat_last = fire && (cnt == LAST);
  assign res_take  = r_valid && (state == ST_COLLECT);
  assign err_flags = err_q;

  tpu_bridge_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CW(CW)) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_ok && in_w_rgn),
    .widx       (host_addr[IDX_W-1:0]),
    .wdata      (host_wdata),
    .host_idx   (host_addr[IDX_W-1:0]),
    .host_rdata (w_host),
    .strm_idx   (cnt),
    .strm_rdata (w_strm)
  );

  tpu_bridge_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CW(CW)) u_abuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_ok && in_a_rgn),
    .widx       (host_addr[IDX_W-1:0]),
    .wdata      (host_wdata),
    .host_idx   (host_addr[IDX_W-1:0]),
    .host_rdata (a_host),
    .strm_idx   (cnt),
    .strm_rdata (a_strm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (host_start) state_nx = ST_SEND_W;
      ST_SEND_W:        if (beat_last) state_nx = ST_SEND_A;
      ST_SEND_A:        if (beat_last) state_nx = ST_COLLECT;
      ST_COLLECT:       if (r_valid && (rcnt == LAST)) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  // Stream outputs depend only on state and cnt; neither moves during a stall
  // and the buffers cannot be written while busy, so the beat holds steady.
  always_comb begin
    s_valid   = 1'b0;
    s_sel     = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    host_busy = 1'b0;
    host_done = 1'b0;
    case (state)
      ST_SEND_W: begin
        s_valid   = 1'b1;
        s_data    = w_strm;
        host_busy = 1'b1;
      end
      ST_SEND_A: begin
        s_valid   = 1'b1;
        s_sel     = 1'b1;
        s_data    = a_strm;
        s_last    = cnt == LAST;
        host_busy = 1'b1;
      end
      ST_COLLECT: host_busy = 1'b1;
      ST_DONE:    host_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      rcnt  <= '0;
      err_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        result[i] <= '0;
      end
    end else begin
      if (start_ok) begin
        cnt  <= '0;
        rcnt <= '0;
      end else begin
        if (fire) begin
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        if (res_take) begin
          rcnt <= rcnt + 1'b1;
        end
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (res_take && (rcnt == CW'(i))) begin
          result[i] <= r_data;
        end
      end

      // Start clears first; a stray result on the start edge still latches.
      if (start_ok) begin
        err_q <= '0;
      end
      if (host_we && !host_idle) begin
        err_q[ERR_WR_BUSY] <= 1'b1;
      end
      if (r_valid && (state != ST_COLLECT)) begin
        err_q[ERR_RES_STRAY] <= 1'b1;
      end
    end
  end

  always_comb begin
    host_rdata = 8'h00;
    if (in_w_rgn) begin
      host_rdata = w_host;
    end else if (in_a_rgn) begin
      host_rdata = a_host;
    end else if (in_r_rgn) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef TPU_BRIDGE_RESULT_SAT_EN
        if (host_addr[6:0] == 7'(i)) begin
          host_rdata = sat_s8(result[i]);
        end
`else
        if (host_addr[6:1] == 6'(i)) begin
          host_rdata = host_addr[0] ? result[i][15:8] : result[i][7:0];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_tpu_host_bridge.sv
// tb/tb_tpu_host_bridge.sv - scoreboard bench for tpu_host_bridge against an address-map reference model
module tb_tpu_host_bridge;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_we = 1'b0;
  logic        host_start = 1'b0;
  logic [7:0]  host_rdata;
  logic        host_busy;
  logic        host_done;
  logic [1:0]  err_flags;
  logic [7:0]  s_data;
  logic        s_sel;
  logic        s_last;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [15:0] r_data = '0;
  logic        r_valid = 1'b0;

  always #5 clk = ~clk;

  tpu_host_bridge #(.DEPTH(DEPTH), .DATA_W(8), .ACC_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_start (host_start),
    .host_rdata (host_rdata),
    .host_busy  (host_busy),
    .host_done  (host_done),
    .err_flags  (err_flags),
    .s_data     (s_data),
    .s_sel      (s_sel),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .r_data     (r_data),
    .r_valid    (r_valid)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sel;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [7:0]  w_m [DEPTH];
  logic [7:0]  a_m [DEPTH];
  logic [15:0] r_m [DEPTH];
  logic [1:0]  err_m;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      w_m[i] = 8'h00;
      a_m[i] = 8'h00;
      r_m[i] = 16'h0000;
    end
    err_m = 2'b00;
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    int ai;
    ai = a;
    if (ai < DEPTH) w_m[ai] = d;
    else if (ai >= 'h40 && ai < 'h40 + DEPTH) a_m[ai - 'h40] = d;
  endfunction

  function automatic logic [7:0] sat_m(input logic [15:0] v);
    int s;
    s = $signed(v);
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    int ai;
    ai = a;
    if (ai < DEPTH) return w_m[ai];
    if (ai >= 'h40 && ai < 'h40 + DEPTH) return a_m[ai - 'h40];
`ifdef TPU_BRIDGE_RESULT_SAT_EN
    if (ai >= 'h80 && ai < 'h80 + DEPTH) return sat_m(r_m[ai - 'h80]);
`else
    if (ai >= 'h80 && ai < 'h80 + 2 * DEPTH) begin
      if ((ai % 2) == 1) return r_m[(ai - 'h80) / 2][15:8];
      return r_m[(ai - 'h80) / 2][7:0];
    end
`endif
    return 8'h00;
  endfunction

  // Stream monitor: every accepted beat is popped and compared; a beat held
  // under backpressure must reappear unchanged on the next cycle.
  initial begin
    beat_t prev;
    bit    prev_stall;
    beat_t e;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {s_valid, s_data, s_sel, s_last}, {1'b1, prev.data, prev.sel, prev.last});
        if (s_valid && s_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data 0x%0h sel %0d with empty scoreboard", s_data, s_sel);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {s_data, s_sel, s_last}, {e.data, e.sel, e.last});
          end
        end
        prev_stall = s_valid && !s_ready;
        prev.data = s_data;
        prev.sel = s_sel;
        prev.last = s_last;
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 0;
    model_write(a, d);
  endtask

  task automatic rd_chk(input logic [7:0] a);
    host_addr = a;
    #1;
    chk($sformatf("rd_%02h", a), host_rdata, exp_read(a));
  endtask

  task automatic rd_all();
    for (int a = 0; a < 256; a++) rd_chk(8'(a));
  endtask

  task automatic start_run(input bit with_we, input logic [7:0] a, input logic [7:0] d);
    host_start = 1;
    if (with_we) begin
      host_we = 1; host_addr = a; host_wdata = d;
      model_write(a, d);
    end
    @(posedge clk); #1;
    host_start = 0; host_we = 0;
    err_m = 2'b00;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{data: w_m[i], sel: 1'b0, last: 1'b0});
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{data: a_m[i], sel: 1'b1, last: (i == DEPTH - 1)});
    chk("start_status", {host_busy, host_done, err_flags}, {1'b1, 1'b0, 2'b00});
  endtask

  task automatic run_stream(input int mode, input bit inject_write, output int cycles);
    bit injected;
    bit busy_ok;
    injected = 0;
    busy_ok = 1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 2000) begin
      case (mode)
        0: s_ready = 1;
        1: s_ready = ~s_ready;
        default: s_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject_write && !injected && s_valid && s_sel) begin
        host_we = 1; host_addr = 8'h45; host_wdata = ~a_m[5];
        injected = 1;
        err_m[0] = 1'b1;
      end
      if (!host_busy) busy_ok = 0;
      @(posedge clk); #1;
      host_we = 0;
      cycles++;
    end
    s_ready = 0;
    chk("stream_drained", exp_q.size(), 0);
    chk("busy_during_stream", busy_ok, 1);
    chk("collect_idle_stream", {s_valid, host_busy, host_done}, {1'b0, 1'b1, 1'b0});
  endtask

  task automatic feed_results(input int mode);
    logic [15:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      if (mode == 0) v = 16'h1234 + 16'(i);
      else if (mode == 1 && i == 3) v = 16'hFF00;
      else v = 16'($urandom);
      r_m[i] = v;
      r_valid = 1; r_data = v;
      if (i == DEPTH - 1) chk("done_before_last", {host_busy, host_done}, {1'b1, 1'b0});
      @(posedge clk); #1;
    end
    r_valid = 0;
    chk("done_after_last", {host_busy, host_done}, {1'b0, 1'b1});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {host_rdata, host_busy, host_done, err_flags, s_data, s_sel, s_last, s_valid}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic write/readback and random map coverage.
    wr(8'h03, 8'hA5);
    wr(8'h40, 8'h11);
    host_addr = 8'h03; #1;
    chk("rd_w3_const", host_rdata, 8'hA5);
    host_addr = 8'h40; #1;
    chk("rd_a0_const", host_rdata, 8'h11);
    for (int k = 0; k < 40; k++) wr(8'($urandom), 8'($urandom));
    rd_all();

    // Full-rate run with ramp data.
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 8'(i));
    for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i), 8'h40 + 8'(i));
    start_run(0, 8'h00, 8'h00);
    run_stream(0, 0, cyc);
    chk("beats_back_to_back", cyc, 2 * DEPTH);
    feed_results(0);
`ifdef TPU_BRIDGE_RESULT_SAT_EN
    host_addr = 8'h80; #1;
    chk("rd_res0_sat", host_rdata, 8'h7F);
`else
    host_addr = 8'h80; #1;
    chk("rd_res0_lo", host_rdata, 8'h34);
    host_addr = 8'h81; #1;
    chk("rd_res0_hi", host_rdata, 8'h12);
`endif
    for (int a = 'h80; a < 'hA2; a++) rd_chk(8'(a));

    // Restart from DONE with alternating backpressure.
    start_run(0, 8'h00, 8'h00);
    run_stream(1, 0, cyc);
    feed_results(1);
    rd_all();

    // Random data, random backpressure, write dropped while busy, stray result.
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 8'($urandom));
    for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i), 8'($urandom));
    start_run(0, 8'h00, 8'h00);
    run_stream(2, 1, cyc);
    feed_results(1);
    r_valid = 1; r_data = 16'hBEEF;
    @(posedge clk); #1;
    r_valid = 0;
    err_m[1] = 1'b1;
    chk("err_both", err_flags, err_m);
    chk("err_both_const", err_flags, 2'b11);
`ifdef TPU_BRIDGE_RESULT_SAT_EN
    host_addr = 8'h83; #1;
    chk("rd_sat_neg", host_rdata, 8'h80);
`endif
    rd_all();
    start_run(0, 8'h00, 8'h00);
    run_stream(2, 0, cyc);
    feed_results(2);

    // Asynchronous reset in the middle of the weight phase.
    start_run(0, 8'h00, 8'h00);
    s_ready = 1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    chk("midrun_rst_outputs", {host_busy, host_done, err_flags, s_data, s_sel, s_last, s_valid}, 0);
    exp_q.delete();
    model_clear();
    s_ready = 0;
    @(posedge clk); #1;
    rst_n = 1;
    rd_all();
    r_valid = 1; r_data = 16'h1111;
    @(posedge clk); #1;
    r_valid = 0;
    chk("err_stray_idle", err_flags, 2'b10);
    start_run(1, 8'h00, 8'h77);
    run_stream(0, 0, cyc);
    feed_results(2);
    rd_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tpu_host_bridge.md
Name: tpu_host_bridge

Overview:
- Sits directly downstream of the UART command processor; consumes its byte writes, start pulses and result-read address.
- Holds weight, activation and result buffers.
- On start, streams weights then activations to the systolic engine over a valid/ready port, then captures DEPTH results.
- Drives busy/done status back to the UART side and serves result bytes combinationally for readback.

Parameters:
DEPTH, 16, entries per buffer (legal 1..16)
DATA_W, 8, weight/activation width (fixed 8; host bus is byte-wide)
ACC_W, 16, result width from engine (fixed 16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_addr  in  8  byte address from UART side
host_wdata  in  8  write data
host_we  in  1  one-cycle write strobe
host_start  in  1  one-cycle start pulse
host_rdata  out  8  read data for host_addr (combinational)
host_busy  out  1  high while a run is in progress
host_done  out  1  high after run completes until next accepted start
err_flags  out  2  sticky: [0] write dropped while busy, [1] result received outside COLLECT
s_data  out  8  stream byte to engine
s_sel  out  1  0 = weight beat, 1 = activation beat
s_last  out  1  final activation beat
s_valid  out  1  stream valid
s_ready  in  1  engine ready
r_data  in  16  result from engine
r_valid  in  1  result strobe (no backpressure)

Behaviour:
- Clock clk, asynchronous active-low reset rst_n. Reset forces all outputs, buffers, counters and flags to 0 and the FSM to IDLE, including mid-run.
- Address map:
  - 0x00+i: weight[i], write and read.
  - 0x40+i: act[i], write and read.
  - 0x80+2i / 0x81+2i: result[i] low / high byte, read-only.
  - i < DEPTH in every region. All other addresses: writes ignored, reads return 0x00.
- host_rdata is a zero-latency combinational mux on host_addr. The value is valid in the same cycle the address is presented.
- Writes:
  - Accepted only in IDLE or DONE; they land at the clock edge.
  - A write in SEND_W, SEND_A or COLLECT is dropped and sets err_flags[0].
- FSM states: IDLE, SEND_W, SEND_A, COLLECT, DONE.
  - IDLE/DONE + host_start -> SEND_W. Clears host_done, err_flags and the beat/result counters. host_busy goes high the next cycle.
  - SEND_W: s_valid=1, s_sel=0, s_data=weight[cnt]. A beat transfers when s_valid&&s_ready. After the beat with cnt=DEPTH-1 -> SEND_A, cnt=0.
  - SEND_A: same, with s_sel=1 and act[cnt]. s_last=1 when cnt=DEPTH-1. After that beat -> COLLECT.
  - COLLECT: s_valid=0. Each r_valid stores r_data into result[rcnt] and increments rcnt. On the DEPTH-th result -> DONE; host_busy drops and host_done rises in the following cycle.
  - DONE: host_done=1 and buffers are readable. Stays in DONE until host_start.
- s_data, s_sel and s_last are held stable while s_valid && !s_ready.
- host_start while busy is ignored, with no flag.
- r_valid outside COLLECT: data discarded, err_flags[1] set.
- Simultaneous host_we and host_start in IDLE: the write commits and the run starts on the same edge, so the run streams the new byte.
- Counters are ceil(log2(DEPTH))+1 bits; no wrap-around occurs inside a run.

Optional Feature:
TPU_BRIDGE_RESULT_SAT_EN
- Defined: result region is 0x80+i. Each read returns result[i] saturated as signed to int8 (>127 -> 0x7F, <-128 -> 0x80).
- Undefined: byte-split low/high readback as described above.

Decomposition:
- tpu_bridge_pkg holds the region base constants (0x00, 0x40, 0x80), the FSM state enum and the err_flags bit indices.
- One sub-module, tpu_bridge_buf: DEPTH x DATA_W register buffer with one write port, one async read port for the host and one read port for the streamer. Instantiated twice, for weights and activations.
- Results are stored in the top level.

Test Plan:
1. Write weight[3]=0xA5 and act[0]=0x11, read 0x03 and 0x40 -> host_rdata 0xA5, then 0x11, each in the same cycle the address is presented.
2. Load weights 0..15 and activations 0x40..0x4F, pulse start with s_ready=1 -> 32 consecutive beats; s_sel flips at beat 16; s_last only on beat 31 with data 0x4F; host_busy high throughout.
3. Same run with s_ready toggling 1/0 every cycle -> no beats lost or duplicated; data stable during stalls.
4. Feed 16 results of 0x1234+i -> host_done rises the cycle after the 16th; read 0x80 -> 0x34, read 0x81 -> 0x12. With TPU_BRIDGE_RESULT_SAT_EN: 0x80 -> 0x7F, and a result of 0xFF00 reads as 0x80.
5. Write during SEND_A, plus r_valid while in IDLE -> buffer unchanged, err_flags=2'b11. Next start clears err_flags to 0.
6. Assert rst_n low mid-SEND_W -> all outputs 0 and buffers 0. A subsequent start streams zeros.
